// File: rtl/scan_decoder.sv
// One-hot decoder with optional auto-scan (define SCAN_DECODER_AUTOSCAN_EN to enable).
// All outputs are registered; the one-hot pattern is built per output line.

module scan_decoder_bit #(
  parameter int SEL_W = 2,
  parameter int LANE  = 0
) (
  input  logic [SEL_W-1:0] sel,
  output logic             hit
);
  assign hit = (sel == SEL_W'(LANE));
endmodule

module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      i,
  input  logic                  load,
  output logic [(2**SEL_W)-1:0] o,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);
  localparam int OUT_W = 2**SEL_W;

  // Index that will be driven after the coming edge; decoded per line below.
  logic [SEL_W-1:0] sel_d;
  logic [OUT_W-1:0] hot;

  for (genvar g = 0; g < OUT_W; g++) begin : g_line
    scan_decoder_bit #(.SEL_W(SEL_W), .LANE(g)) u_bit (
      .sel (sel_d),
      .hit (hot[g])
    );
  end

`ifdef SCAN_DECODER_AUTOSCAN_EN
  localparam int PW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t        state;
  logic [PW-1:0] pre;
  logic          adv;

  assign adv = (pre == PW'(DWELL-1));

  // Load beats advance; entering scan starts on the current idx without advancing.
  always_comb begin
    sel_d = idx;
    if (en && !mode)
      sel_d = i;
    else if (en && mode && load)
      sel_d = i;
    else if (en && mode && state == SCAN && adv)
      sel_d = idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      idx   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      pre   <= '0;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state <= IDLE;
        o     <= '0;
        valid <= 1'b0;
        pre   <= '0;
      end else if (!mode) begin
        state <= DIRECT;
        o     <= hot;
        idx   <= sel_d;
        valid <= 1'b1;
        pre   <= '0;
      end else begin
        state <= SCAN;
        o     <= hot;
        idx   <= sel_d;
        valid <= 1'b1;
        if (load || state != SCAN || adv)
          pre <= '0;
        else
          pre <= pre + 1'b1;
        wrap  <= (state == SCAN) && !load && adv && (idx == {SEL_W{1'b1}});
      end
    end
  end
`else
  typedef enum logic {IDLE, DIRECT} state_t;
  state_t state;

  assign sel_d = i;
  assign wrap  = 1'b0;

  // Scan controls have no effect in this build.
  logic unused_ok;
  assign unused_ok = ^{load, mode, state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      o     <= '0;
      valid <= 1'b0;
    end else begin
      state <= DIRECT;
      o     <= hot;
      idx   <= sel_d;
      valid <= 1'b1;
    end
  end
`endif

endmodule
